// File: rtl/fixed_point_seq_divider.sv
// Sequential signed fixed-point divider: restoring division on operand magnitudes,
// one quotient bit per clock, then sign restore and clamping to the WIDTH-bit range.
module fixed_point_seq_divider #(
   parameter int WIDTH = 24,
   parameter int FRAC  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic             div_by_zero,
   output logic             saturated
);

   localparam int N  = WIDTH + FRAC;
   localparam int CW = $clog2(N + 1);

   localparam logic [WIDTH:0]   ONE_M   = {{WIDTH{1'b0}}, 1'b1};
   localparam logic [N-1:0]     ONE_N   = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-1:0]     NEG_LIM = ONE_N << (WIDTH - 1);
   localparam logic [N-1:0]     POS_LIM = NEG_LIM - ONE_N;
   localparam logic [WIDTH-1:0] MAX_Q   = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_Q   = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t           state_q;
   logic [N-1:0]     nq_q;
   logic [WIDTH:0]   rem_q;
   logic [WIDTH:0]   dvs_q;
   logic [CW-1:0]    cnt_q;
   logic             neg_q;
   logic [WIDTH-1:0] quot_q;
   logic             dbz_q;
   logic             sat_q;

   logic [WIDTH:0]   dvd_mag_s;
   logic [WIDTH:0]   dvs_mag_s;
   logic [WIDTH:0]   trial_s;
   logic [WIDTH:0]   rem_d;
   logic             bit_s;
   logic [N-1:0]     nq_d;
   logic [WIDTH-1:0] res_d;
   logic             sat_d;

   // nq_q shifts numerator bits out at the top while quotient bits enter at the bottom
   always_comb begin
      dvd_mag_s = {dividend[WIDTH-1], dividend};
      dvs_mag_s = {divisor[WIDTH-1], divisor};
      if (dividend[WIDTH-1]) begin
         dvd_mag_s = ~{dividend[WIDTH-1], dividend} + ONE_M;
      end else begin
         dvd_mag_s = {dividend[WIDTH-1], dividend};
      end
      if (divisor[WIDTH-1]) begin
         dvs_mag_s = ~{divisor[WIDTH-1], divisor} + ONE_M;
      end else begin
         dvs_mag_s = {divisor[WIDTH-1], divisor};
      end

      trial_s = (rem_q << 1) | {{WIDTH{1'b0}}, nq_q[N-1]};
      if (trial_s >= dvs_q) begin
         bit_s = 1'b1;
         rem_d = trial_s - dvs_q;
      end else begin
         bit_s = 1'b0;
         rem_d = trial_s;
      end
      nq_d = {nq_q[N-2:0], bit_s};

      // nq_d is the full magnitude only on the last iteration, which is the only time res_d is used
      res_d = WIDTH'(nq_d);
      sat_d = 1'b0;
      if (neg_q) begin
         if (nq_d > NEG_LIM) begin
            res_d = MIN_Q;
            sat_d = 1'b1;
         end else begin
            res_d = WIDTH'(~nq_d + ONE_N);
            sat_d = 1'b0;
         end
      end else begin
         if (nq_d > POS_LIM) begin
            res_d = MAX_Q;
            sat_d = 1'b1;
         end else begin
            res_d = WIDTH'(nq_d);
            sat_d = 1'b0;
         end
      end
   end

   // Control FSM and all datapath/result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         nq_q    <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         quot_q  <= '0;
         dbz_q   <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  if (dvs_mag_s == '0) begin
                     state_q <= DONE;
                     quot_q  <= dividend[WIDTH-1] ? MIN_Q : MAX_Q;
                     dbz_q   <= 1'b1;
                     sat_q   <= 1'b1;
                  end else begin
                     state_q <= DIVIDE;
                     nq_q    <= N'(dvd_mag_s) << FRAC;
                     rem_q   <= '0;
                     dvs_q   <= dvs_mag_s;
                     neg_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                     cnt_q   <= CW'(N - 1);
                  end
               end
            end
            DIVIDE: begin
               nq_q  <= nq_d;
               rem_q <= rem_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == '0) begin
                  state_q <= DONE;
                  quot_q  <= res_d;
                  dbz_q   <= 1'b0;
                  sat_q   <= sat_d;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign quotient    = quot_q;
   assign div_by_zero = dbz_q;
   assign saturated   = sat_q;

endmodule

// File: tb/tb_fixed_point_seq_divider.sv
// Directed bench for fixed_point_seq_divider at WIDTH=24, FRAC=8 with hand-computed results.
module tb_fixed_point_seq_divider;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] dividend;
   logic [23:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] quotient;
   logic        div_by_zero;
   logic        saturated;

   int total_cnt  = 0;
   int passed_cnt = 0;

   fixed_point_seq_divider #(.WIDTH(24), .FRAC(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .div_by_zero (div_by_zero),
      .saturated   (saturated)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) passed_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Called #1 after a rising edge; returns #1 after the accepting edge.
   task automatic accept(input string tag, input logic [23:0] a, input logic [23:0] b);
      check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag, input int exp_lat, input logic [23:0] exp_q,
                              input logic exp_dbz, input logic exp_sat);
      int lat;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_quotient"}, {8'd0, quotient}, {8'd0, exp_q});
      check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
      check({tag, "_sat"}, {31'd0, saturated}, {31'd0, exp_sat});
   endtask

   task automatic release_result(input string tag, input logic [23:0] exp_q);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
      check({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_q_kept"}, {8'd0, quotient}, {8'd0, exp_q});
   endtask

   task automatic run_op(input string tag, input logic [23:0] a, input logic [23:0] b,
                         input int exp_lat, input logic [23:0] exp_q,
                         input logic exp_dbz, input logic exp_sat);
      accept(tag, a, b);
      wait_result(tag, exp_lat, exp_q, exp_dbz, exp_sat);
      release_result(tag, exp_q);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = 24'h000000;
      divisor   = 24'h000000;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_quotient", {8'd0, quotient}, 32'd0);
      check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      check("rst_sat", {31'd0, saturated}, 32'd0);
      reset = 1'b0;

      run_op("six_by_two", 24'h000600, 24'h000200, 33, 24'h000300, 1'b0, 1'b0);
      run_op("neg_quarter", 24'hFFFF00, 24'h000400, 33, 24'hFFFFC0, 1'b0, 1'b0);

      // 1/3 with a held result and busy-time input noise
      accept("third", 24'h000100, 24'h000300);
      wait_result("third", 33, 24'h000055, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         dividend = 24'($urandom);
         divisor  = 24'($urandom);
         @(posedge clk);
         #1;
         check("hold_valid", {31'd0, out_valid}, 32'd1);
         check("hold_in_ready", {31'd0, in_ready}, 32'd0);
         check("hold_quotient", {8'd0, quotient}, 32'h000055);
         check("hold_flags", {30'd0, div_by_zero, saturated}, 32'd0);
      end
      in_valid = 1'b0;
      release_result("third", 24'h000055);

      run_op("pos_by_zero", 24'h000500, 24'h000000, 1, 24'h7FFFFF, 1'b1, 1'b1);
      run_op("neg_by_zero", 24'hFFFB00, 24'h000000, 1, 24'h800000, 1'b1, 1'b1);
      run_op("pos_sat", 24'h7FFFFF, 24'h000001, 33, 24'h7FFFFF, 1'b0, 1'b1);
      run_op("most_neg", 24'h800000, 24'h000100, 33, 24'h800000, 1'b0, 1'b0);
      run_op("neg_by_neg", 24'hFFF400, 24'hFFFE00, 33, 24'h000600, 1'b0, 1'b0);

      // Reset five cycles into DIVIDE aborts the operation
      accept("abort", 24'h000600, 24'h000200);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      check("abort_busy", {31'd0, in_ready}, 32'd0);
      #2;
      reset = 1'b1;
      #1;
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_quotient", {8'd0, quotient}, 32'd0);
      check("abort_flags", {30'd0, div_by_zero, saturated}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         check("abort_no_result", {31'd0, out_valid}, 32'd0);
      end
      run_op("after_abort", 24'h000600, 24'h000200, 33, 24'h000300, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed_cnt, total_cnt);
      $finish;
   end

endmodule
